// File: rtl/apu_pkg.sv
// Shared APU frame-sequencer definitions: step type and per-step schedule masks.
package apu_pkg;

  localparam int FS_STEPS = 8;

  typedef logic [2:0] fs_step_t;

  // Bit n set means step n clocks that unit.
  localparam logic [FS_STEPS-1:0] FS_LENGTH_STEPS = 8'b0101_0101;
  localparam logic [FS_STEPS-1:0] FS_SWEEP_STEPS  = 8'b0100_0100;
  localparam logic [FS_STEPS-1:0] FS_ENV_STEPS    = 8'b1000_0000;

endpackage

// File: rtl/div_edge_detect.sv
// Falling-edge detector on the selected DIV tap bit; optional CGB tap mux
// under APU_CGB_DOUBLE_SPEED_EN.
module div_edge_detect #(
  parameter int TAP_NORMAL = 4,
  parameter int TAP_DOUBLE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cpu_en,
  input  logic [7:0] i_div,
`ifdef APU_CGB_DOUBLE_SPEED_EN
  input  logic       i_double_speed,
`endif
  output logic       o_edge
);

  logic w_tap;
  logic r_div_prev;
  logic w_unused;

`ifdef APU_CGB_DOUBLE_SPEED_EN
  // A speed switch that drops the tap from 1 to 0 is a real edge.
  assign w_tap = i_double_speed ? i_div[TAP_DOUBLE] : i_div[TAP_NORMAL];
`else
  assign w_tap = i_div[TAP_NORMAL];
`endif

  // Only the tap bits matter; fold the rest so they are visibly consumed.
  assign w_unused = ^{i_div, (TAP_DOUBLE > 7)};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_prev <= 1'b0;
    end else if (i_cpu_en) begin
      r_div_prev <= w_tap;
    end
  end

  assign o_edge = i_cpu_en & r_div_prev & ~w_tap;

endmodule

// File: rtl/apu_frame_sequencer.sv
// 512 Hz APU frame sequencer: step counter and length/sweep/envelope strobes.
// Optional CGB double-speed tap selection with APU_CGB_DOUBLE_SPEED_EN.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int TAP_NORMAL = 4,
  parameter int TAP_DOUBLE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       apu_on,
  input  logic [7:0] div,
`ifdef APU_CGB_DOUBLE_SPEED_EN
  input  logic       double_speed,
`endif
  output logic       length_clk,
  output logic       sweep_clk,
  output logic       envelope_clk,
  output logic       length_skip,
  output logic [2:0] step
);

  logic     w_edge;
  logic     w_fire;
  fs_step_t r_step;
  logic     r_length_clk;
  logic     r_sweep_clk;
  logic     r_envelope_clk;

  div_edge_detect #(
    .TAP_NORMAL(TAP_NORMAL),
    .TAP_DOUBLE(TAP_DOUBLE)
  ) u_edge (
    .clk           (clk),
    .reset         (reset),
    .i_cpu_en      (cpu_en),
    .i_div         (div),
`ifdef APU_CGB_DOUBLE_SPEED_EN
    .i_double_speed(double_speed),
`endif
    .o_edge        (w_edge)
  );

  assign w_fire = w_edge & apu_on;

  // Powered-off APU parks at step 0 so the first edge after power-on is step 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step         <= '0;
      r_length_clk   <= 1'b0;
      r_sweep_clk    <= 1'b0;
      r_envelope_clk <= 1'b0;
    end else if (cpu_en) begin
      if (!apu_on) begin
        r_step         <= '0;
        r_length_clk   <= 1'b0;
        r_sweep_clk    <= 1'b0;
        r_envelope_clk <= 1'b0;
      end else begin
        r_length_clk   <= w_fire & FS_LENGTH_STEPS[r_step];
        r_sweep_clk    <= w_fire & FS_SWEEP_STEPS[r_step];
        r_envelope_clk <= w_fire & FS_ENV_STEPS[r_step];
        if (w_fire) begin
          r_step <= r_step + 3'd1;
        end
      end
    end
  end

  assign length_clk   = r_length_clk;
  assign sweep_clk    = r_sweep_clk;
  assign envelope_clk = r_envelope_clk;
  assign length_skip  = r_step[0];
  assign step         = r_step;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer; double-speed steps only when
// APU_CGB_DOUBLE_SPEED_EN is defined.
module tb_apu_frame_sequencer;

  logic       clk;
  logic       reset;
  logic       cpu_en;
  logic       apu_on;
  logic [7:0] div;
`ifdef APU_CGB_DOUBLE_SPEED_EN
  logic       double_speed;
`endif
  logic       length_clk;
  logic       sweep_clk;
  logic       envelope_clk;
  logic       length_skip;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;

  apu_frame_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_en      (cpu_en),
    .apu_on      (apu_on),
    .div         (div),
`ifdef APU_CGB_DOUBLE_SPEED_EN
    .double_speed(double_speed),
`endif
    .length_clk  (length_clk),
    .sweep_clk   (sweep_clk),
    .envelope_clk(envelope_clk),
    .length_skip (length_skip),
    .step        (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed {envelope, sweep, length} for compact strobe checks.
  function automatic logic [7:0] strobes();
    return {5'd0, envelope_clk, sweep_clk, length_clk};
  endfunction

  initial begin
    logic [7:0] exp_s;
    reset  = 1'b1;
    cpu_en = 1'b1;
    apu_on = 1'b0;
    div    = 8'h00;
`ifdef APU_CGB_DOUBLE_SPEED_EN
    double_speed = 1'b0;
`endif
    tick();
    tick();
    check("reset_step", {5'd0, step}, 8'd0);
    check("reset_strobes", strobes(), 8'd0);
    check("reset_skip", {7'd0, length_skip}, 8'd0);

    // Full eight-step cycle with cpu_en every cycle.
    reset  = 1'b0;
    apu_on = 1'b1;
    div    = 8'h10;
    tick();
    check("arm_strobes", strobes(), 8'd0);
    for (int i = 1; i <= 8; i++) begin
      div = 8'h00;
      tick();
      exp_s = 8'd0;
      if (i % 2 == 1) exp_s[0] = 1'b1;
      if (i == 3 || i == 7) exp_s[1] = 1'b1;
      if (i == 8) exp_s[2] = 1'b1;
      check($sformatf("seq_strobe_e%0d", i), strobes(), exp_s);
      check($sformatf("seq_step_e%0d", i), {5'd0, step}, 8'(i % 8));
      check($sformatf("seq_skip_e%0d", i), {7'd0, length_skip}, 8'(i % 2));
      div = 8'h10;
      tick();
      check($sformatf("seq_width_e%0d", i), strobes(), 8'd0);
    end

    // APU off: edges ignored, step parked at 0.
    apu_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      div = 8'h00;
      tick();
      check($sformatf("off_strobes_%0d", i), strobes(), 8'd0);
      check($sformatf("off_step_%0d", i), {5'd0, step}, 8'd0);
      div = 8'h10;
      tick();
    end
    apu_on = 1'b1;
    tick();
    check("on_no_strobe", strobes(), 8'd0);
    div = 8'h00;
    tick();
    check("on_first_edge", strobes(), 8'h01);
    check("on_first_step", {5'd0, step}, 8'd1);

    // DIV write clearing the tap at step 1 counts as an edge.
    div = 8'h10;
    tick();
    div = 8'h00;
    tick();
    check("divwr_strobes", strobes(), 8'd0);
    check("divwr_step", {5'd0, step}, 8'd2);

    // Sparse cpu_en: strobe held over the whole enable interval.
    div = 8'h10;
    tick();
    div = 8'h00;
    tick();
    cpu_en = 1'b0;
    check("sparse_strobe_0", strobes(), 8'h03);
    for (int i = 1; i < 4; i++) begin
      div = (i == 1) ? 8'h10 : 8'h00;
      tick();
      check($sformatf("sparse_strobe_%0d", i), strobes(), 8'h03);
      check($sformatf("sparse_step_%0d", i), {5'd0, step}, 8'd3);
    end
    cpu_en = 1'b1;
    tick();
    check("sparse_clear", strobes(), 8'd0);
    check("sparse_step_final", {5'd0, step}, 8'd3);
    check("sparse_skip", {7'd0, length_skip}, 8'd1);

    // Advance to step 5, then reset coincident with an edge.
    for (int i = 0; i < 2; i++) begin
      div = 8'h10;
      tick();
      div = 8'h00;
      tick();
    end
    check("pre_reset_step", {5'd0, step}, 8'd5);
    div = 8'h10;
    tick();
    div   = 8'h00;
    reset = 1'b1;
    tick();
    check("midreset_step", {5'd0, step}, 8'd0);
    check("midreset_strobes", strobes(), 8'd0);
    check("midreset_skip", {7'd0, length_skip}, 8'd0);
    reset = 1'b0;
    div   = 8'h10;
    tick();
    div = 8'h00;
    tick();
    check("post_reset_edge", strobes(), 8'h01);
    check("post_reset_step", {5'd0, step}, 8'd1);

`ifdef APU_CGB_DOUBLE_SPEED_EN
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    double_speed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      div = 8'h10;
      tick();
      div = 8'h00;
      tick();
      check($sformatf("ds_tap4_strobes_%0d", i), strobes(), 8'd0);
      check($sformatf("ds_tap4_step_%0d", i), {5'd0, step}, 8'd0);
    end
    div = 8'h20;
    tick();
    div = 8'h00;
    tick();
    check("ds_tap5_strobes", strobes(), 8'h01);
    check("ds_tap5_step", {5'd0, step}, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- 512 Hz frame sequencer for the APU. It derives length, sweep and envelope clock strobes from a falling-edge tap on the DIV register.
- Sits between the timer/DIV block and the four channel generators (pulse1, pulse2, pattern, noise) that feed the wave mixer.
- Honours the NR52 master enable (apu_on): when the APU is off, the sequencer is held at step 0 and emits no strobes.

Parameters:
- TAP_NORMAL, default 4: index of the DIV upper-byte bit whose falling edge advances the sequencer at normal speed.
- TAP_DOUBLE, default 5: tap bit used in CGB double-speed mode. Only meaningful with APU_CGB_DOUBLE_SPEED_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset (see Behaviour).
- cpu_en  in  1  CPU-rate clock enable; all state advances only on cycles with cpu_en=1.
- apu_on  in  1  NR52 bit 7 master enable.
- div  in  8  upper byte of the DIV counter (FF04).
- length_clk  out  1  strobe: clock the length counters.
- sweep_clk  out  1  strobe: clock the pulse1 frequency sweep.
- envelope_clk  out  1  strobe: clock the volume envelopes.
- length_skip  out  1  high when the next step will not clock length (next step is odd); used by the length-enable extra-clock quirk.
- step  out  3  index of the next step to execute.
- double_speed  in  1  CGB KEY1 speed flag. Present only with APU_CGB_DOUBLE_SPEED_EN.

Behaviour:
- Reset is synchronous, active-high, on clk. While reset is high:
  - step = 0, div_prev = 0;
  - length_clk, sweep_clk, envelope_clk = 0;
  - length_skip = 0.
- Edge detect: tap = div[TAP_NORMAL].
  - div_prev <= tap on every cpu_en cycle, regardless of apu_on.
  - edge = cpu_en & div_prev & ~tap.
  - A DIV write that clears a tap bit which was 1 is a legitimate edge. No special handling.
- Schedule, executing the current step then step <= step+1 (wrap 7 -> 0):
  - step 0: length.
  - step 1: none.
  - step 2: length and sweep.
  - step 3: none.
  - step 4: length.
  - step 5: none.
  - step 6: length and sweep.
  - step 7: envelope.
- Strobes are registered and updated only on cpu_en cycles.
  - Each strobe is set when (edge & apu_on & step matches) and cleared on the next cpu_en cycle otherwise.
  - A strobe is therefore high for exactly one cpu_en interval.
  - Latency: the strobe is visible the clk cycle after the cpu_en cycle that saw the edge.
- length_skip = step[0], combinational from the step register.
- apu_on = 0: step is forced to 0 and all strobes to 0 on cpu_en cycles; edges are ignored. div_prev keeps tracking.
- apu_on 0 -> 1: no strobe on that cycle unless a genuine edge coincides.
  - The first edge after power-on executes step 0 (length).
  - An edge in the same cpu_en cycle as apu_on rising executes step 0.
- cpu_en = 0: all registers hold, including the strobes.
- Reset mid-sequence returns step to 0. Any strobe in flight is dropped.

Optional Feature:
- Macro APU_CGB_DOUBLE_SPEED_EN.
- Defined: double_speed port exists; tap = double_speed ? div[TAP_DOUBLE] : div[TAP_NORMAL], so the frame rate stays 512 Hz at double CPU speed.
- A speed switch that changes the tap value is treated like any other tap transition: a 1 -> 0 change is an edge.
- Undefined: port absent; tap = div[TAP_NORMAL] always.

Decomposition:
- Shared apu_pkg holds:
  - localparam FS_STEPS = 8;
  - typedef logic [2:0] fs_step_t;
  - constant masks FS_LENGTH_STEPS = 8'b0101_0101, FS_SWEEP_STEPS = 8'b0100_0100, FS_ENV_STEPS = 8'b1000_0000, indexed by step.
- One sub-module, div_edge_detect: tap mux plus div_prev register, producing edge. The step register and schedule decode stay in the top level.

Test Plan:
- Toggle div[4] 1->0 eight times with apu_on=1, cpu_en every cycle -> length_clk on edges 1,3,5,7; sweep_clk on 3,7; envelope_clk on 8; step returns to 0; each strobe is 1 cycle wide.
- apu_on=0 with 4 falling edges on div[4], then apu_on=1 and one edge -> no strobes while off; the first edge after power-on gives length_clk=1, sweep_clk=0, and step=1.
- cpu_en high every 4th cycle, with an edge during an enabled cycle -> the strobe stays high for 4 clk cycles and the step advances only once.
- DIV write forcing div from 8'h10 to 8'h00 at step 1 -> treated as an edge: no strobe and step=2; the next edge gives length_clk and sweep_clk.
- Assert reset at step 5 with envelope pending -> step=0, all strobes 0, length_skip=0 on the next cycle.
- With APU_CGB_DOUBLE_SPEED_EN and double_speed=1, toggling only div[4] gives no edges; a div[5] 1->0 transition gives length_clk at step 0.
